// File: rtl/multi_input_gate_sweep_if.sv
// Request/result bundle of the N-input gate: direct operand, sweep control,
// streamed results and sweep status.
interface multi_input_gate_sweep_if #(
    parameter int N     = 5,
    parameter int CNT_W = N + 1
) ();
    logic [1:0]       mode;
    logic [N-1:0]     in_vec;
    logic             in_valid;
    logic             start;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic [N-1:0]     out_vec;
    logic [CNT_W-1:0] ones_count;
    logic             busy;
    logic             done;

    modport slave (
        input  mode, in_vec, in_valid, start, abort,
        output x, x_valid, out_vec, ones_count, busy, done
    );

    modport master (
        output mode, in_vec, in_valid, start, abort,
        input  x, x_valid, out_vec, ones_count, busy, done
    );
endinterface

// File: rtl/multi_input_gate_sweep.sv
// N-input AND/OR/XOR/MAJORITY gate with registered output and an exhaustive
// sweep engine that streams the full truth table and counts its ones.
module multi_input_gate_sweep #(
    parameter int N     = 5,
    parameter int CNT_W = N + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_input_gate_sweep_if.slave bus
);
    localparam int PC_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [N-1:0]     cnt_q;
    logic             x_q;
    logic             x_valid_q;
    logic [N-1:0]     out_vec_q;
    logic [CNT_W-1:0] ones_q;
    logic             dir_x_d;
    logic             sweep_x_d;

    // Majority is strictly more than half, so an even-N tie evaluates to 0.
    function automatic logic gate_f(input logic [1:0] m, input logic [N-1:0] v);
        logic [PC_W-1:0] pc;
        pc = '0;
        for (int i = 0; i < N; i++) begin
            pc = pc + PC_W'(v[i]);
        end
        case (m)
            2'b00:   gate_f = &v;
            2'b01:   gate_f = |v;
            2'b10:   gate_f = ^v;
            default: gate_f = (pc > PC_W'(N / 2));
        endcase
    endfunction

    always_comb begin
        dir_x_d   = gate_f(bus.mode, bus.in_vec);
        sweep_x_d = gate_f(mode_q, cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 2'b00;
            cnt_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            out_vec_q <= '0;
            ones_q    <= '0;
        end else begin
            x_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        cnt_q   <= '0;
                        ones_q  <= '0;
                        state_q <= SWEEP;
                    end else if (bus.in_valid) begin
                        x_q       <= dir_x_d;
                        out_vec_q <= bus.in_vec;
                        x_valid_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else begin
                        x_q       <= sweep_x_d;
                        out_vec_q <= cnt_q;
                        x_valid_q <= 1'b1;
                        ones_q    <= ones_q + CNT_W'(sweep_x_d);
                        cnt_q     <= cnt_q + N'(1);
                        // Leaving on the all-ones vector keeps the counter wrap harmless.
                        if (&cnt_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.x          = x_q;
    assign bus.x_valid    = x_valid_q;
    assign bus.out_vec    = out_vec_q;
    assign bus.ones_count = ones_q;
    assign bus.busy       = (state_q == SWEEP);
    assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_multi_input_gate_sweep.sv
// Directed bench for the multi-input gate sweep block at N=5, N=4 and N=16,
// with a result scoreboard per instance.
module tb_multi_input_gate_sweep;
    typedef struct {
        logic [15:0] vec;
        logic        x;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   strobes5 = 0, dones5 = 0;
    int   strobes4 = 0, dones4 = 0;
    int   strobes16 = 0, dones16 = 0;
    exp_t q5[$], q4[$], q16[$];
    exp_t e5, e4, e16;

    always #5 clk = ~clk;

    multi_input_gate_sweep_if #(.N(5))  b5 ();
    multi_input_gate_sweep_if #(.N(4))  b4 ();
    multi_input_gate_sweep_if #(.N(16)) b16 ();

    multi_input_gate_sweep #(.N(5))  d5  (.clk(clk), .rst(rst), .bus(b5));
    multi_input_gate_sweep #(.N(4))  d4  (.clk(clk), .rst(rst), .bus(b4));
    multi_input_gate_sweep #(.N(16)) d16 (.clk(clk), .rst(rst), .bus(b16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_f(input logic [1:0] m, input logic [15:0] v, input int n);
        int pc;
        pc = 0;
        for (int i = 0; i < n; i++) pc += int'(v[i]);
        case (m)
            2'b00:   return (pc == n);
            2'b01:   return (pc > 0);
            2'b10:   return (pc % 2) == 1;
            default: return (2 * pc > n);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors sample on the falling edge.
    always @(negedge clk) begin
        if (b5.x_valid === 1'b1) begin
            strobes5++;
            if (q5.size() == 0) check("d5_extra_strobe", 32'(b5.out_vec), 32'hFFFF_FFFF);
            else begin
                e5 = q5.pop_front();
                check("d5_out_vec", 32'(b5.out_vec), 32'(e5.vec[4:0]));
                check("d5_x", 32'(b5.x), 32'(e5.x));
            end
        end
        if (b5.done === 1'b1) begin
            dones5++;
            check("d5_done_vec", 32'(b5.out_vec), 32'd31);
            check("d5_done_xvalid", 32'(b5.x_valid), 32'd1);
        end
    end

    always @(negedge clk) begin
        if (b4.x_valid === 1'b1) begin
            strobes4++;
            if (q4.size() == 0) check("d4_extra_strobe", 32'(b4.out_vec), 32'hFFFF_FFFF);
            else begin
                e4 = q4.pop_front();
                check("d4_out_vec", 32'(b4.out_vec), 32'(e4.vec[3:0]));
                check("d4_x", 32'(b4.x), 32'(e4.x));
            end
        end
        if (b4.done === 1'b1) dones4++;
    end

    always @(negedge clk) begin
        if (b16.x_valid === 1'b1) begin
            strobes16++;
            if (q16.size() == 0) check("d16_extra_strobe", 32'(b16.out_vec), 32'hFFFF_FFFF);
            else begin
                e16 = q16.pop_front();
                if (b16.out_vec !== e16.vec || b16.x !== e16.x) begin
                    check("d16_vec_x", {15'd0, b16.x, b16.out_vec}, {15'd0, e16.x, e16.vec});
                end
            end
        end
        if (b16.done === 1'b1) dones16++;
    end

    task automatic sweep5(input logic [1:0] m, input int exp_ones, input bit disturb, input string tag);
        int busy_c;
        bit seen;
        for (int v = 0; v < 32; v++) q5.push_back('{vec: 16'(v), x: model_f(m, 16'(v), 5)});
        strobes5 = 0;
        dones5   = 0;
        busy_c   = 0;
        seen     = 1'b0;
        b5.mode  = m;
        b5.start = 1'b1;
        b5.in_valid = disturb;
        b5.in_vec   = 5'b11111;
        tick();
        b5.start    = 1'b0;
        b5.in_valid = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (b5.busy === 1'b1) busy_c++;
            if (b5.done === 1'b1) seen = 1'b1;
            else begin
                if (disturb) begin
                    b5.mode     = (c >= 4) ? 2'b00 : m;
                    b5.in_valid = (c == 6 || c == 7);
                    b5.start    = (c == 9 || c == 20);
                end
                tick();
            end
        end
        b5.mode = m; b5.in_valid = 1'b0; b5.start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_ones"}, 32'(b5.ones_count), 32'(exp_ones));
        tick();
        check({tag, "_done_clear"}, 32'(b5.done), 32'd0);
        check({tag, "_busy_clear"}, 32'(b5.busy), 32'd0);
        check({tag, "_strobes"}, 32'(strobes5), 32'd32);
        check({tag, "_dones"}, 32'(dones5), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_c), 32'd32);
        check({tag, "_sb_empty"}, 32'(q5.size()), 32'd0);
        tick();
        check({tag, "_ones_hold"}, 32'(b5.ones_count), 32'(exp_ones));
    endtask

    initial begin
        int  busy_c;
        bit  seen;
        logic [4:0] rv;
        logic [1:0] rm;

        b5.mode = 0;  b5.in_vec = 0;  b5.in_valid = 0;  b5.start = 0;  b5.abort = 0;
        b4.mode = 0;  b4.in_vec = 0;  b4.in_valid = 0;  b4.start = 0;  b4.abort = 0;
        b16.mode = 0; b16.in_vec = 0; b16.in_valid = 0; b16.start = 0; b16.abort = 0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_x", 32'(b5.x), 0);
        check("rst_x_valid", 32'(b5.x_valid), 0);
        check("rst_out_vec", 32'(b5.out_vec), 0);
        check("rst_ones", 32'(b5.ones_count), 0);
        check("rst_busy", 32'(b5.busy), 0);
        check("rst_done", 32'(b5.done), 0);
        check("rst_d16_ones", 32'(b16.ones_count), 0);
        rst = 1'b0;
        tick();

        // Direct mode, one request at a time.
        for (int m = 0; m < 4; m++) begin
            q5.push_back('{vec: 16'b10110, x: model_f(2'(m), 16'b10110, 5)});
            b5.mode = 2'(m); b5.in_vec = 5'b10110; b5.in_valid = 1'b1;
            tick();
            b5.in_valid = 1'b0;
            check("dir_latency_vld", 32'(b5.x_valid), 1);
            tick();
            check("dir_vld_drop", 32'(b5.x_valid), 0);
        end
        check("dir_ones_unchanged", 32'(b5.ones_count), 0);

        // Back-to-back direct requests.
        for (int m = 0; m < 4; m++) begin
            q5.push_back('{vec: 16'b10110, x: model_f(2'(m), 16'b10110, 5)});
            b5.mode = 2'(m); b5.in_vec = 5'b10110; b5.in_valid = 1'b1;
            tick();
            check("b2b_vld", 32'(b5.x_valid), 1);
        end
        b5.in_valid = 1'b0;
        tick();
        check("hold_vld", 32'(b5.x_valid), 0);
        check("hold_x", 32'(b5.x), 1);
        check("hold_out_vec", 32'(b5.out_vec), 32'b10110);

        for (int k = 0; k < 8; k++) begin
            rv = 5'($urandom);
            rm = 2'($urandom);
            q5.push_back('{vec: 16'(rv), x: model_f(rm, 16'(rv), 5)});
            b5.mode = rm; b5.in_vec = rv; b5.in_valid = 1'b1;
            tick();
        end
        b5.in_valid = 1'b0;
        tick();
        check("dir_sb_empty", 32'(q5.size()), 0);

        sweep5(2'b00, 1,  1'b0, "sw_and");
        sweep5(2'b01, 31, 1'b0, "sw_or");
        sweep5(2'b10, 16, 1'b0, "sw_xor");
        sweep5(2'b11, 16, 1'b0, "sw_maj");
        sweep5(2'b01, 31, 1'b1, "sw_immune");

        // Abort an OR sweep once vector 9 has been streamed.
        for (int v = 0; v < 10; v++) q5.push_back('{vec: 16'(v), x: model_f(2'b01, 16'(v), 5)});
        strobes5 = 0; dones5 = 0; seen = 1'b0;
        b5.mode = 2'b01; b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (b5.x_valid === 1'b1 && b5.out_vec === 5'd9) seen = 1'b1;
            else tick();
        end
        check("abort_reached_9", 32'(seen), 1);
        b5.abort = 1'b1;
        tick();
        b5.abort = 1'b0;
        check("abort_busy", 32'(b5.busy), 0);
        check("abort_vld", 32'(b5.x_valid), 0);
        check("abort_ones", 32'(b5.ones_count), 9);
        for (int c = 0; c < 5; c++) tick();
        check("abort_strobes", 32'(strobes5), 10);
        check("abort_no_done", 32'(dones5), 0);
        check("abort_ones_hold", 32'(b5.ones_count), 9);
        sweep5(2'b01, 31, 1'b0, "sw_after_abort");

        // Reset in the middle of an XOR sweep.
        for (int v = 0; v < 32; v++) q5.push_back('{vec: 16'(v), x: model_f(2'b10, 16'(v), 5)});
        seen = 1'b0;
        b5.mode = 2'b10; b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (b5.x_valid === 1'b1 && b5.out_vec === 5'd11) seen = 1'b1;
            else tick();
        end
        check("rstmid_reached_11", 32'(seen), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q5.delete();
        check("rstmid_x", 32'(b5.x), 0);
        check("rstmid_vld", 32'(b5.x_valid), 0);
        check("rstmid_out_vec", 32'(b5.out_vec), 0);
        check("rstmid_ones", 32'(b5.ones_count), 0);
        check("rstmid_busy", 32'(b5.busy), 0);
        check("rstmid_done", 32'(b5.done), 0);
        tick();
        check("rstmid_idle", 32'(b5.busy), 0);
        q5.push_back('{vec: 16'b00111, x: model_f(2'b11, 16'b00111, 5)});
        b5.mode = 2'b11; b5.in_vec = 5'b00111; b5.in_valid = 1'b1;
        tick();
        b5.in_valid = 1'b0;
        check("post_rst_dir_vld", 32'(b5.x_valid), 1);
        check("post_rst_dir_x", 32'(b5.x), 1);
        tick();

        // N=4 majority sweep: ties evaluate to 0.
        for (int v = 0; v < 16; v++) q4.push_back('{vec: 16'(v), x: model_f(2'b11, 16'(v), 4)});
        strobes4 = 0; dones4 = 0; seen = 1'b0; busy_c = 0;
        b4.mode = 2'b11; b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (b4.busy === 1'b1) busy_c++;
            if (b4.done === 1'b1) seen = 1'b1;
            else tick();
        end
        check("n4_done_seen", 32'(seen), 1);
        check("n4_ones", 32'(b4.ones_count), 5);
        tick();
        check("n4_strobes", 32'(strobes4), 16);
        check("n4_dones", 32'(dones4), 1);
        check("n4_busy_cycles", 32'(busy_c), 16);
        check("n4_sb_empty", 32'(q4.size()), 0);

        // N=16 AND sweep: full 65536-vector pass without counter wrap.
        for (int v = 0; v < 65536; v++) q16.push_back('{vec: 16'(v), x: (v == 65535)});
        strobes16 = 0; dones16 = 0; seen = 1'b0;
        b16.mode = 2'b00; b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        for (int c = 0; c < 66000 && !seen; c++) begin
            if (b16.done === 1'b1) seen = 1'b1;
            else tick();
        end
        check("n16_done_seen", 32'(seen), 1);
        check("n16_done_vec", 32'(b16.out_vec), 32'hFFFF);
        check("n16_ones", 32'(b16.ones_count), 1);
        for (int c = 0; c < 4; c++) tick();
        check("n16_strobes", 32'(strobes16), 65536);
        check("n16_dones", 32'(dones16), 1);
        check("n16_ones_hold", 32'(b16.ones_count), 1);
        check("n16_sb_empty", 32'(q16.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multi_input_gate_sweep.md
Name: multi_input_gate_sweep

Overview:
Parametrised N-input reduction gate with a registered output and four selectable functions (AND, OR, XOR, MAJORITY).
It has two uses:
- Direct mode: evaluates one presented input vector per request.
- Sweep mode: an internal FSM walks all 2^N input combinations, streams each result, and counts how many evaluate to 1.

It is the hardware, self-checking successor of the fixed 5-input gate. It serves as a truth-table generator and built-in self-test block in the lab designs.

Parameters:
- N, 5, number of gate inputs; legal range 2..16.
- CNT_W, N+1, width of ones_count; must hold the value 2^N.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  gate function: 00 AND, 01 OR, 10 XOR, 11 MAJORITY.
- in_vec  input  N  operand for direct mode.
- in_valid  input  1  direct-mode evaluate request.
- start  input  1  begin an exhaustive sweep.
- abort  input  1  terminate a sweep in progress.
- x  output  1  registered gate result.
- x_valid  output  1  one-cycle strobe: x and out_vec are new.
- out_vec  output  N  the input vector that produced x.
- ones_count  output  CNT_W  number of 1 results in the current or last sweep.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle strobe when a sweep completes.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; x=0, x_valid=0, out_vec=0, ones_count=0, busy=0, done=0. Reset has priority over all inputs, including mid-sweep.
- Function f(v):
  - AND: &v.
  - OR: |v.
  - XOR: ^v.
  - MAJORITY: popcount(v) > N/2, strictly greater. For even N a tie gives 0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - start=1: latch mode into mode_q, clear sweep counter cnt and ones_count, go to SWEEP. Any in_valid in the same cycle is dropped.
  - else in_valid=1: next edge sets x=f(in_vec) using the live mode, out_vec=in_vec, x_valid=1. Latency is 1 cycle; back-to-back requests give results every cycle. ones_count is unchanged.
  - x_valid is 0 in any cycle with no evaluation; x and out_vec hold their last values.
- SWEEP:
  - busy=1. in_valid, start and mode changes are ignored; mode_q is used throughout.
  - abort=0: each edge sets x=f_q(cnt), out_vec=cnt, x_valid=1, ones_count += f_q(cnt), cnt += 1.
  - When cnt = 2^N-1 is evaluated, go to DONE. cnt must not wrap into a second pass.
  - abort=1: no evaluation that cycle (x_valid=0), go to IDLE. ones_count keeps its partial value and done stays 0.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - This coincides with the final x_valid (out_vec = 2^N-1) and with ones_count at its final value.
  - Next state is IDLE; start is ignored in DONE.
- Timing: start sampled at cycle t gives x_valid at cycles t+2 .. t+2^N+1, which is 2^N strobes. done is at t+2^N+1.
- ones_count holds after a sweep until the next start or reset.
- busy is a decode of state==SWEEP; done is a decode of state==DONE. Both are glitch-free registered-state outputs.

Test Plan:
- Direct mode, N=5: in_valid with in_vec=5'b10110 under each mode:
  - AND → x=0; OR → x=1; XOR → x=1; MAJ → x=1 (popcount 3).
  - Each result appears with x_valid one cycle later and out_vec=10110.
  - Back-to-back in_valid gives consecutive x_valid.
- Sweep, N=5, for each mode:
  - Exactly 32 x_valid strobes, with out_vec running 0..31 in order.
  - Final ones_count: AND=1, OR=31, XOR=16, MAJ=16.
  - One done pulse, coincident with out_vec=31; busy high for exactly 32 cycles.
- Sweep immunity, N=5 OR sweep:
  - Toggling mode to AND mid-sweep, plus in_valid and start pulses during SWEEP, leaves the result unchanged: ones_count=31, 32 strobes.
  - start and in_valid asserted together in IDLE → sweep starts and no direct result is produced.
- Abort, N=5 OR sweep: assert abort in the cycle x_valid shows out_vec=9 → no further x_valid, ones_count=9, done never asserts, busy=0 next cycle. A new start then completes normally with 31.
- Reset mid-sweep, N=5: rst after about 12 strobes → next cycle all outputs are 0 and state is IDLE. A following direct request works.
- Parameter check, N=4 MAJ sweep (even-N tie rule) → 16 strobes, ones_count=5. N=16 AND sweep → 65536 strobes, ones_count=1 with no counter wrap.
